// File: rtl/cwdarr_rx.sv
// cwdarr_rx -- codeword-array receive buffer and timed issue stage.
//
// Buffers {codeword array, timing, opcode} entries from the PSU in a small
// FIFO. Each entry is issued to the QXU after waiting its own timing value
// in idle cycles, counted from the edge that makes it the head entry.
//
// Ports:
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   psu_valid    upstream entry present
//   cwdarray_in  per-physical-qubit codeword array
//   timing_in    idle cycles to wait before issuing this entry
//   opcode_in    opcode tag
//   cwdgen_stall backpressure to the PSU, high while the buffer is full
//   qxu_stall    downstream not ready; a due issue is held
//   qxu_valid    one-cycle pulse per issued entry
//   cwdarray_out last issued codeword array
//   opcode_out   last issued opcode
//   count        buffer occupancy, 0..DEPTH
module cwdarr_rx #(
  parameter int DEPTH_BW  = 2,
  parameter int NUM_PQ    = 4,
  parameter int CWD_BW    = 8,
  parameter int TIME_BW   = 8,
  parameter int OPCODE_BW = 4,
  parameter logic [OPCODE_BW-1:0] INVALID_OPCODE = '1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        psu_valid,
  input  logic [NUM_PQ*CWD_BW-1:0]    cwdarray_in,
  input  logic [TIME_BW-1:0]          timing_in,
  input  logic [OPCODE_BW-1:0]        opcode_in,
  output logic                        cwdgen_stall,
  input  logic                        qxu_stall,
  output logic                        qxu_valid,
  output logic [NUM_PQ*CWD_BW-1:0]    cwdarray_out,
  output logic [OPCODE_BW-1:0]        opcode_out,
  output logic [DEPTH_BW:0]           count
);

  localparam int DEPTH = 1 << DEPTH_BW;
  localparam int CW    = NUM_PQ * CWD_BW;
  localparam logic [DEPTH_BW:0] FULL_CNT = (DEPTH_BW + 1)'(DEPTH);
  localparam logic [DEPTH_BW:0] ONE_CNT  = (DEPTH_BW + 1)'(1);

  typedef enum logic {IDLE, WAIT} state_t;

  logic [CW-1:0]        cwd_mem  [DEPTH];
  logic [TIME_BW-1:0]   time_mem [DEPTH];
  logic [OPCODE_BW-1:0] op_mem   [DEPTH];

  logic [DEPTH_BW-1:0]  wr_ptr;
  logic [DEPTH_BW-1:0]  rd_ptr;
  logic [DEPTH_BW-1:0]  rd_ptr_nxt;
  logic [TIME_BW-1:0]   wait_cnt;
  state_t               state;
  logic                 push;
  logic                 pop;

  // Full blocks the push even when a pop happens on the same edge, so the
  // stall is a pure function of the registered occupancy.
  assign cwdgen_stall = (count == FULL_CNT);
  assign push         = psu_valid && !cwdgen_stall;
  assign pop          = (state == WAIT) && (wait_cnt == '0) && !qxu_stall;
  assign rd_ptr_nxt   = rd_ptr + DEPTH_BW'(1);

  // NOTE: storage carries no reset; entries are only read once count says
  // they were written, so clearing them would buy nothing.
  always_ff @(posedge clk) begin
    if (push) begin
      cwd_mem[wr_ptr]  <= cwdarray_in;
      time_mem[wr_ptr] <= timing_in;
      op_mem[wr_ptr]   <= opcode_in;
    end
  end

  // NOTE: all state here uses non-blocking assignments so every branch reads
  // the pre-edge values of count, rd_ptr and wait_cnt.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      state        <= IDLE;
      wait_cnt     <= '0;
      qxu_valid    <= 1'b0;
      cwdarray_out <= '0;
      opcode_out   <= INVALID_OPCODE;
    end else begin
      // Pulse output: defaults low, raised only on an issuing edge.
      qxu_valid <= 1'b0;

      if (push) wr_ptr <= wr_ptr + DEPTH_BW'(1);
      if (pop)  rd_ptr <= rd_ptr_nxt;

      unique case ({push, pop})
        2'b10:   count <= count + ONE_CNT;
        2'b01:   count <= count - ONE_CNT;
        default: ;
      endcase

      unique case (state)
        IDLE: begin
          if (count != '0) begin
            state    <= WAIT;
            wait_cnt <= time_mem[rd_ptr];
          end
        end
        WAIT: begin
          if (wait_cnt != '0) begin
            // Idle countdown proceeds even while the QXU is stalled.
            wait_cnt <= wait_cnt - TIME_BW'(1);
          end else if (!qxu_stall) begin
            qxu_valid    <= 1'b1;
            cwdarray_out <= cwd_mem[rd_ptr];
            opcode_out   <= op_mem[rd_ptr];
            // Another entry is already buffered: start its countdown now so
            // back-to-back issues are spaced by that entry's timing + 1.
            if (count > ONE_CNT) wait_cnt <= time_mem[rd_ptr_nxt];
            else                 state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cwdarr_rx.sv
// tb_cwdarr_rx -- self-checking bench for cwdarr_rx.
// A scoreboard queue holds expected {cwdarray, opcode} pairs pushed as the
// PSU presents entries; a negedge monitor pops and compares on every
// qxu_valid pulse and checks that outputs hold between issues. Scenario
// tasks check latencies, backpressure, stalls, wrap-around and reset.
module tb_cwdarr_rx;

  localparam int DEPTH_BW = 2;
  localparam int NUM_PQ   = 4;
  localparam int CWD_BW   = 8;
  localparam int TIME_BW  = 8;
  localparam int OB       = 4;
  localparam int CW       = NUM_PQ * CWD_BW;
  localparam logic [OB-1:0] INVALID_OP = 4'hF;

  typedef struct packed {
    logic [CW-1:0] cwd;
    logic [OB-1:0] op;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst;
  logic                psu_valid;
  logic [CW-1:0]       cwdarray_in;
  logic [TIME_BW-1:0]  timing_in;
  logic [OB-1:0]       opcode_in;
  logic                cwdgen_stall;
  logic                qxu_stall;
  logic                qxu_valid;
  logic [CW-1:0]       cwdarray_out;
  logic [OB-1:0]       opcode_out;
  logic [DEPTH_BW:0]   count;

  cwdarr_rx #(
    .DEPTH_BW(DEPTH_BW), .NUM_PQ(NUM_PQ), .CWD_BW(CWD_BW),
    .TIME_BW(TIME_BW), .OPCODE_BW(OB), .INVALID_OPCODE(INVALID_OP)
  ) dut (
    .clk(clk), .rst(rst), .psu_valid(psu_valid), .cwdarray_in(cwdarray_in),
    .timing_in(timing_in), .opcode_in(opcode_in), .cwdgen_stall(cwdgen_stall),
    .qxu_stall(qxu_stall), .qxu_valid(qxu_valid), .cwdarray_out(cwdarray_out),
    .opcode_out(opcode_out), .count(count)
  );

  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   issue_cnt = 0;
  int   issue_edges[$];
  exp_t sb[$];
  exp_t mon_exp;
  exp_t mon_got;
  logic [CW-1:0] last_cwd = '0;
  logic [OB-1:0] last_op = INVALID_OP;
  bit   mon_en = 1'b0;

  // Edge counter: after rising edge n and before the next one, cyc == n.
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (mon_en) begin
      mon_got.cwd = cwdarray_out;
      mon_got.op  = opcode_out;
      checks++;
      if (qxu_valid === 1'b1) begin
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_issue edge=%0d got cwd=%h op=%h, none expected",
                   cyc, cwdarray_out, opcode_out);
          last_cwd = cwdarray_out;
          last_op  = opcode_out;
        end else begin
          mon_exp = sb.pop_front();
          if (mon_got !== mon_exp) begin
            errors++;
            $display("FAIL issue_data edge=%0d got cwd=%h op=%h expected cwd=%h op=%h",
                     cyc, mon_got.cwd, mon_got.op, mon_exp.cwd, mon_exp.op);
          end
          last_cwd = mon_exp.cwd;
          last_op  = mon_exp.op;
        end
        issue_edges.push_back(cyc);
        issue_cnt++;
      end else if (qxu_valid !== 1'b0 || cwdarray_out !== last_cwd || opcode_out !== last_op) begin
        errors++;
        $display("FAIL output_hold edge=%0d got valid=%b cwd=%h op=%h expected valid=0 cwd=%h op=%h",
                 cyc, qxu_valid, cwdarray_out, opcode_out, last_cwd, last_op);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Presents one entry and holds it until an edge with cwdgen_stall low
  // captures it; returns that edge number. psu_valid is left high.
  task automatic push_entry(input logic [CW-1:0] cwd, input logic [TIME_BW-1:0] t,
                            input logic [OB-1:0] op, output int edge_no);
    exp_t e;
    psu_valid   = 1'b1;
    cwdarray_in = cwd;
    timing_in   = t;
    opcode_in   = op;
    e.cwd = cwd;
    e.op  = op;
    sb.push_back(e);
    checks++;
    for (int i = 0; i < 200; i++) begin
      if (!cwdgen_stall) begin
        step();
        edge_no = cyc;
        return;
      end
      step();
    end
    errors++;
    edge_no = -1;
    $display("FAIL push_timeout op=%h still stalled after 200 cycles", op);
  endtask

  task automatic wait_issues(input int n, input int budget);
    checks++;
    for (int i = 0; i < budget; i++) begin
      if (issue_cnt >= n) return;
      step();
    end
    errors++;
    $display("FAIL issue_timeout got %0d issues expected %0d", issue_cnt, n);
  endtask

  task automatic test_reset();
    rst = 1'b1; psu_valid = 1'b0; qxu_stall = 1'b0;
    cwdarray_in = '0; timing_in = '0; opcode_in = '0;
    step();
    step();
    mon_en = 1'b1;
    checks++;
    if (count !== '0) begin errors++; $display("FAIL reset_count got %0d expected 0", count); end
    checks++;
    if (cwdgen_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b expected 0", cwdgen_stall); end
    checks++;
    if (qxu_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b expected 0", qxu_valid); end
    checks++;
    if (opcode_out !== INVALID_OP || cwdarray_out !== '0) begin
      errors++; $display("FAIL reset_outputs got op=%h cwd=%h expected op=%h cwd=0", opcode_out, cwdarray_out, INVALID_OP);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    int e;
    int base = issue_cnt;
    issue_edges.delete();
    push_entry(32'hA5A5_0001, 8'd0, 4'd5, e);
    psu_valid = 1'b0;
    wait_issues(base + 1, 20);
    checks++;
    if (issue_edges.size() < 1 || issue_edges[0] !== e + 2) begin
      errors++; $display("FAIL single_latency got edge %0d expected %0d",
                         (issue_edges.size() > 0) ? issue_edges[0] : -1, e + 2);
    end
    step();
    checks++;
    if (qxu_valid !== 1'b0) begin errors++; $display("FAIL single_pulse_width got valid=%b expected 0", qxu_valid); end
    checks++;
    if (count !== '0) begin errors++; $display("FAIL single_count got %0d expected 0", count); end
  endtask

  task automatic test_timing();
    int ea, eb;
    int base = issue_cnt;
    issue_edges.delete();
    push_entry(32'h1111_000A, 8'd3, 4'd1, ea);
    push_entry(32'h2222_000B, 8'd1, 4'd2, eb);
    psu_valid = 1'b0;
    wait_issues(base + 2, 40);
    checks++;
    if (eb !== ea + 1) begin errors++; $display("FAIL timing_push_edges got %0d expected %0d", eb, ea + 1); end
    checks++;
    if (issue_edges.size() < 2 || issue_edges[0] !== ea + 5 || issue_edges[1] !== ea + 7) begin
      errors++; $display("FAIL timing_issue_edges got %0d,%0d expected %0d,%0d",
                         (issue_edges.size() > 0) ? issue_edges[0] : -1,
                         (issue_edges.size() > 1) ? issue_edges[1] : -1, ea + 5, ea + 7);
    end
    step();
  endtask

  task automatic test_full();
    int e;
    int e5;
    int base = issue_cnt;
    issue_edges.delete();
    qxu_stall = 1'b1;
    for (int i = 0; i < 4; i++) push_entry(32'hF000_0000 + 32'(i), 8'd0, OB'(8 + i), e);
    // Fifth entry held while full; bench tracks its expectation separately.
    cwdarray_in = 32'hF000_0004; timing_in = 8'd0; opcode_in = 4'd12;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (count !== 3'd4 || cwdgen_stall !== 1'b1) begin
        errors++; $display("FAIL full_state got count=%0d stall=%b expected count=4 stall=1", count, cwdgen_stall);
      end
      checks++;
      if (issue_cnt !== base) begin errors++; $display("FAIL full_no_issue got %0d issues expected %0d", issue_cnt, base); end
      step();
    end
    qxu_stall = 1'b0;
    push_entry(32'hF000_0004, 8'd0, 4'd12, e5);
    psu_valid = 1'b0;
    wait_issues(base + 5, 40);
    checks++;
    if (issue_edges.size() < 1 || e5 !== issue_edges[0] + 1) begin
      errors++; $display("FAIL full_fifth_capture got edge %0d expected first pop edge + 1 = %0d",
                         e5, (issue_edges.size() > 0) ? issue_edges[0] + 1 : -1);
    end
    repeat (5) step();
    checks++;
    if (issue_cnt !== base + 5 || count !== '0) begin
      errors++; $display("FAIL full_drain got issues=%0d count=%0d expected issues=%0d count=0", issue_cnt, count, base + 5);
    end
  endtask

  task automatic test_downstream_stall();
    int e;
    int f;
    int base = issue_cnt;
    issue_edges.delete();
    qxu_stall = 1'b1;
    push_entry(32'hBEEF_0003, 8'd0, 4'd3, e);
    psu_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (issue_cnt !== base || count !== 3'd1) begin
        errors++; $display("FAIL dstall_hold got issues=%0d count=%0d expected issues=%0d count=1", issue_cnt, count, base);
      end
    end
    qxu_stall = 1'b0;
    f = cyc + 1;
    wait_issues(base + 1, 10);
    repeat (3) step();
    checks++;
    if (issue_cnt !== base + 1 || issue_edges.size() < 1 || issue_edges[0] !== f) begin
      errors++; $display("FAIL dstall_release got issues=%0d edge=%0d expected issues=%0d edge=%0d", issue_cnt,
                         (issue_edges.size() > 0) ? issue_edges[0] : -1, base + 1, f);
    end
  endtask

  task automatic test_wrap();
    int e;
    int e0;
    int base = issue_cnt;
    issue_edges.delete();
    for (int i = 0; i < 10; i++) begin
      push_entry($urandom, 8'd0, OB'($urandom_range(0, 14)), e);
      if (i == 0) e0 = e;
    end
    psu_valid = 1'b0;
    wait_issues(base + 10, 40);
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (issue_edges.size() <= k || issue_edges[k] !== e0 + 2 + k) begin
        errors++; $display("FAIL wrap_issue_edge k=%0d got %0d expected %0d", k,
                           (issue_edges.size() > k) ? issue_edges[k] : -1, e0 + 2 + k);
      end
    end
    step();
    checks++;
    if (count !== '0 || sb.size() != 0) begin
      errors++; $display("FAIL wrap_drain got count=%0d pending=%0d expected 0 and 0", count, sb.size());
    end
  endtask

  task automatic test_max_timing();
    int e;
    int base = issue_cnt;
    issue_edges.delete();
    push_entry(32'h7777_00FF, 8'hFF, 4'd7, e);
    psu_valid = 1'b0;
    wait_issues(base + 1, 300);
    checks++;
    if (issue_edges.size() < 1 || issue_edges[0] !== e + 257) begin
      errors++; $display("FAIL max_timing got edge %0d expected %0d",
                         (issue_edges.size() > 0) ? issue_edges[0] : -1, e + 257);
    end
    step();
  endtask

  task automatic test_reset_midrun();
    int e;
    int base;
    for (int i = 0; i < 3; i++) push_entry(32'hCAFE_0000 + 32'(i), 8'd20, OB'(i), e);
    psu_valid = 1'b0;
    checks++;
    if (count !== 3'd3) begin errors++; $display("FAIL midrun_pre_count got %0d expected 3", count); end
    rst = 1'b1;
    sb.delete();
    last_cwd = '0;
    last_op  = INVALID_OP;
    step();
    rst = 1'b0;
    checks++;
    if (count !== '0 || cwdgen_stall !== 1'b0 || qxu_valid !== 1'b0 || opcode_out !== INVALID_OP) begin
      errors++; $display("FAIL midrun_reset got count=%0d stall=%b valid=%b op=%h expected 0,0,0,%h",
                         count, cwdgen_stall, qxu_valid, opcode_out, INVALID_OP);
    end
    base = issue_cnt;
    repeat (60) step();
    checks++;
    if (issue_cnt !== base) begin errors++; $display("FAIL midrun_late_issue got %0d issues expected %0d", issue_cnt, base); end
    issue_edges.delete();
    push_entry(32'h0BAD_F00D, 8'd1, 4'd9, e);
    psu_valid = 1'b0;
    wait_issues(base + 1, 20);
    checks++;
    if (issue_edges.size() < 1 || issue_edges[0] !== e + 3) begin
      errors++; $display("FAIL midrun_recover got edge %0d expected %0d",
                         (issue_edges.size() > 0) ? issue_edges[0] : -1, e + 3);
    end
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_timing();
    test_full();
    test_downstream_stall();
    test_wrap();
    test_max_timing();
    test_reset_midrun();
    repeat (3) step();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL leftover_expected got %0d pending expected 0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
